// File: rtl/player_input_encoder.sv
// player_input_encoder: debounced direction buttons -> committed turn, life cycle and step strobe
// Ports:
//   clock, reset (async, active-low)
//   btn_up/right/down/left : raw asynchronous buttons, active-high
//   start, game_tick, crash : one-cycle strobes
//   p_info : [1:0] committed dir, [2] alive, [3] step strobe (all registered)
module player_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter logic [1:0] START_DIR = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       start,
  input  logic       game_tick,
  input  logic       crash,
  output logic [3:0] p_info
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DEAD} state_t;
  state_t state, state_n;
  logic [3:0] raw, s1, s2, deb, deb_q, press;
  logic [CW-1:0] cnt [4];
  logic [1:0] dir, pend_d, sel;
  logic pend_v, legal, commit, rearm, to_dead, step, alive;
  assign raw = {btn_left, btn_down, btn_right, btn_up};
  assign press = deb & ~deb_q;
  assign p_info = {step, alive, dir};
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // highest-priority press first, then filter against the currently committed dir
  always_comb begin
    sel = press[0] ? 2'b00 : press[1] ? 2'b01 : press[2] ? 2'b10 : 2'b11;
    legal = |press && sel != dir && sel != (dir ^ 2'b10);
  end
  always_comb begin
    state_n = state;
    rearm = 1'b0;
    case (state)
      IDLE, DEAD: if (start) begin
        state_n = ARMED;
        rearm = 1'b1;
      end
      ARMED: if (game_tick) state_n = RUN;
      RUN: if (crash) state_n = DEAD;
      default: state_n = IDLE;
    endcase
    to_dead = state == RUN && crash;
    commit = state == RUN && game_tick && !crash && pend_v;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dir <= START_DIR;
      alive <= 1'b0;
      step <= 1'b0;
      pend_v <= 1'b0;
      pend_d <= 2'b00;
    end else begin
      state <= state_n;
      alive <= state_n == RUN;
      step <= state == RUN && game_tick && !crash;
      dir <= commit ? pend_d : rearm ? START_DIR : dir;
      // a press arriving with a committing tick survives the commit
      if (rearm || to_dead) pend_v <= 1'b0;
      else if (legal) begin
        pend_v <= 1'b1;
        pend_d <= sel;
      end else if (commit) pend_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_player_input_encoder.sv
// tb_player_input_encoder: directed scoreboard bench for player_input_encoder
module tb_player_input_encoder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic start = 1'b0, game_tick = 1'b0, crash = 1'b0;
  logic [3:0] p_info;
  int n_chk = 0;
  int n_fail = 0;
  string tag_q[$];
  logic [3:0] exp_q[$];
  player_input_encoder #(.DEBOUNCE_CYCLES(4), .START_DIR(2'b01)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .start(start), .game_tick(game_tick), .crash(crash), .p_info(p_info)
  );
  always #5 clock = ~clock;
  task automatic check_out();
    string t;
    logic [3:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    n_chk++;
    assert (p_info === e) else begin
      n_fail++;
      $error("FAIL %s: p_info=%b expected %b", t, p_info, e);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask
  task automatic pulse(input logic s, input logic t, input logic c, input string tag, input logic [3:0] e);
    start = s;
    game_tick = t;
    crash = c;
    step(tag, e);
    start = 1'b0;
    game_tick = 1'b0;
    crash = 1'b0;
  endtask
  task automatic chk_press(input string tag, input logic e);
    n_chk++;
    assert (dut.press[2] === e) else begin
      n_fail++;
      $error("FAIL %s: press_down=%b expected %b", tag, dut.press[2], e);
    end
  endtask
  // mask order {left, down, right, up}; pending is loaded 7 edges after the buttons rise
  task automatic press(input logic [3:0] m, input logic [3:0] e);
    {btn_left, btn_down, btn_right, btn_up} = m;
    repeat (7) step("press_hold", e);
    {btn_left, btn_down, btn_right, btn_up} = 4'b0000;
    repeat (8) step("press_release", e);
  endtask
  initial begin
    step("reset", 4'b0001);
    step("reset", 4'b0001);
    reset = 1'b1;
    pulse(0, 1, 0, "idle_tick", 4'b0001);
    pulse(1, 0, 0, "start", 4'b0001);
    pulse(0, 1, 0, "first_tick", 4'b0101);
    pulse(0, 1, 0, "second_tick", 4'b1101);
    step("after_step", 4'b0101);
    pulse(1, 1, 0, "start_in_run", 4'b1101);
    step("after_step", 4'b0101);
    for (int i = 0; i < 20; i++) begin
      btn_down = ((i / 2) % 2) == 0;
      step("bounce", 4'b0101);
      chk_press("bounce_press", 1'b0);
    end
    btn_down = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step("bounce_hold", 4'b0101);
      chk_press("hold_press", k == 6);
    end
    pulse(0, 1, 0, "bounce_tick", 4'b1110);
    step("bounce_after", 4'b0110);
    btn_down = 1'b0;
    repeat (8) step("bounce_release", 4'b0110);
    press(4'b0010, 4'b0110);
    pulse(0, 1, 0, "to_right", 4'b1101);
    step("to_right_after", 4'b0101);
    press(4'b1000, 4'b0101);
    pulse(0, 1, 0, "reversal", 4'b1101);
    step("reversal_after", 4'b0101);
    press(4'b0001, 4'b0101);
    press(4'b0100, 4'b0101);
    pulse(0, 1, 0, "last_legal", 4'b1110);
    step("last_legal_after", 4'b0110);
    press(4'b0010, 4'b0110);
    pulse(0, 1, 0, "to_right2", 4'b1101);
    step("to_right2_after", 4'b0101);
    press(4'b0101, 4'b0101);
    pulse(0, 1, 0, "priority", 4'b1100);
    step("priority_after", 4'b0100);
    press(4'b0001, 4'b0100);
    pulse(0, 1, 0, "same_dir", 4'b1100);
    press(4'b0010, 4'b0100);
    pulse(0, 1, 0, "to_right3", 4'b1101);
    step("to_right3_after", 4'b0101);
    pulse(0, 1, 1, "crash_tick", 4'b0001);
    step("dead", 4'b0001);
    pulse(0, 1, 0, "dead_tick", 4'b0001);
    pulse(0, 0, 1, "dead_crash", 4'b0001);
    pulse(1, 0, 0, "rearm", 4'b0001);
    pulse(0, 1, 0, "rearm_tick", 4'b0101);
    pulse(0, 1, 0, "rearm_step", 4'b1101);
    step("rearm_after", 4'b0101);
    #3;
    reset = 1'b0;
    #1;
    tag_q.push_back("async_reset");
    exp_q.push_back(4'b0001);
    check_out();
    #2;
    reset = 1'b1;
    pulse(0, 1, 0, "post_reset_tick", 4'b0001);
    pulse(1, 0, 0, "post_reset_start", 4'b0001);
    pulse(0, 1, 0, "post_reset_run", 4'b0101);
    pulse(0, 1, 0, "post_reset_step", 4'b1101);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/player_input_encoder.md
Name: player_input_encoder

Overview:
- Converts one player's four raw direction buttons into the 4-bit player info word consumed by the object-drawing/trace logic.
- Synchronises and debounces the buttons, queues the latest legal turn, and commits it on each game tick.
- Tracks the player life cycle (idle/armed/running/dead).
- Two instances are used, one for p1_info and one for p2_info.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a debounced button level changes (5 ms at 50 MHz).
- START_DIR, 2'b01: direction loaded at reset and on re-arm (00 up, 01 right, 10 down, 11 left).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up  in  1  raw asynchronous button, active-high
- btn_right  in  1  raw asynchronous button, active-high
- btn_down  in  1  raw asynchronous button, active-high
- btn_left  in  1  raw asynchronous button, active-high
- start  in  1  one-cycle strobe: arm/re-arm the player
- game_tick  in  1  one-cycle strobe: movement step
- crash  in  1  one-cycle strobe from collision logic
- p_info  out  4  [1:0] committed dir, [2] alive, [3] step strobe

Behaviour:
- Interface timing: one clock. Reset is asynchronous and active-low. Every flop clears or loads immediately when reset is low.
- Reset values:
  - p_info = {1'b0, 1'b0, START_DIR}
  - state = IDLE
  - pending invalid
  - synchronisers, debounced levels and counters = 0
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Counter is cleared whenever the synchronised level equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.
  - A press event is a 0->1 edge of the debounced level, exactly one cycle wide.
  - Total latency from stable raw level to press event is 2 + DEBOUNCE_CYCLES cycles.
- Pending turn:
  - Multiple press events in the same cycle resolve by priority up > right > down > left.
  - A pressed dir equal to the committed dir is ignored.
  - A pressed dir equal to the committed dir XOR 2'b10 (180° reversal) is ignored.
  - Otherwise the press loads pending, overwriting any earlier pending value.
  - Presses are accepted in every state; pending is cleared at commit, on re-arm, and on entry to DEAD.
- State machine:
  - IDLE: alive=0, no steps. start -> ARMED.
  - ARMED: alive=0. game_tick -> RUN. No commit or step on that tick. Aligns the first move to the tick grid.
  - RUN: alive=1.
    - On game_tick, if pending is valid, dir <= pending and pending is cleared.
    - p_info[3]=1 for exactly the cycle after game_tick.
    - p_info[1:0] shows the new dir in that same cycle (latency 1).
    - crash -> DEAD.
    - start is ignored.
  - DEAD: alive=0, dir frozen, no steps, pending cleared. start -> ARMED, dir <= START_DIR.
- Simultaneous events:
  - crash with game_tick in RUN: crash wins, no commit, no step, and alive=0 the next cycle.
  - start with game_tick in IDLE or DEAD: go to ARMED only; the tick is not consumed.
  - crash outside RUN is ignored.
  - A press in the same cycle as a committing game_tick is checked against the old committed dir and lands in pending after the commit. The commit uses the previous pending value.
- Reset mid-game: all state is discarded immediately and outputs return to reset values in the same cycle reset asserts.
- All p_info bits are registered outputs; there is no combinational path from inputs to p_info.

Test Plan (DEBOUNCE_CYCLES=4, START_DIR=01):
- Reset, then start, game_tick, game_tick:
  - After the first tick, alive=1 and the state is RUN.
  - After the second tick, p_info=4'b1101 for one cycle, then 4'b0101.
- Bouncy input: btn_down toggled every 2 cycles for 20 cycles, then held high:
  - Exactly one press event, 6 cycles after the hold begins.
  - The next game_tick yields p_info[1:0]=10.
- Reversal filter: committed dir right; press left, then tick:
  - dir stays 01 and the step strobe still pulses.
  - Then press up, press down, tick: dir=10 (last legal press wins).
- Priority: up and down debounced on the same cycle while heading right, then tick -> dir=00.
- Crash:
  - crash and game_tick in the same cycle -> no step pulse, p_info=4'b0001 next cycle, further ticks ignored.
  - Then start, tick -> alive=1, dir=01.
- Async reset asserted low mid-RUN between clock edges:
  - p_info=4'b0001 without a clock edge.
  - After release, game_tick is ignored until start.
